// File: rtl/parking_pkg.sv
// Shared types and widths for the parking occupancy controller.
// Latency: none (declarations only).
// Backpressure: not applicable.
package parking_pkg;

  localparam int OCC_W = 8;

  // Encoding matches the adder's sel input: 0 adds, 1 subtracts.
  typedef enum logic {
    ADD = 1'b0,
    SUB = 1'b1
  } op_t;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    CALC   = 2'd1,
    COMMIT = 2'd2
  } state_t;

endpackage

// File: rtl/parking_occupancy_ctrl_if.sv
// Sensor request / gate pulse / display status bundle for the occupancy controller.
// Latency: none (wiring only).
// Backpressure: none; requests are levels, responses are one-cycle pulses.
interface parking_occupancy_ctrl_if;
  import parking_pkg::*;

  logic             entry_req;
  logic             exit_req;
  logic             entry_grant;
  logic             exit_grant;
  logic             entry_reject;
  logic             exit_reject;
  logic [OCC_W-1:0] count;
  logic             full;
  logic             empty;
  logic             busy;
  logic             ovf_err;

  // Sensor side: drives the request levels, observes pulses and status.
  modport master (
    output entry_req, exit_req,
    input  entry_grant, exit_grant, entry_reject, exit_reject,
    input  count, full, empty, busy, ovf_err
  );

  // Controller side.
  modport slave (
    input  entry_req, exit_req,
    output entry_grant, exit_grant, entry_reject, exit_reject,
    output count, full, empty, busy, ovf_err
  );

endinterface

// File: rtl/adder_sub_8bit.sv
// 8-bit adder/subtractor: Z = A + B (sel=0) or A - B (sel=1), Cout is the carry out.
// Latency: combinational.
// Backpressure: none.
module adder_sub_8bit
  import parking_pkg::*;
(
  input  logic [OCC_W-1:0] A,
  input  logic [OCC_W-1:0] B,
  input  logic             sel,
  output logic [OCC_W-1:0] Z,
  output logic             Cout
);

  logic [OCC_W:0] sum;

  // Two's-complement subtract: invert B and inject sel as the carry in.
  assign sum = {1'b0, A} + {1'b0, B ^ {OCC_W{sel}}} + {{OCC_W{1'b0}}, sel};
  assign Z    = sum[OCC_W-1:0];
  assign Cout = sum[OCC_W];

endmodule

// File: rtl/parking_occupancy_ctrl.sv
// Entry/exit request edges -> +/-1 on the occupancy count through one shared adder.
// Latency: accepted op grants 3 cycles after the pending bit sets; reject/paired grant after 1.
// Backpressure: none; one pending request per direction is held while busy, extra rises merge.
module parking_occupancy_ctrl
  import parking_pkg::*;
#(
  parameter int CAPACITY = 200
) (
  input  logic                      clk,
  input  logic                      rst_n,
  parking_occupancy_ctrl_if.slave   bus
);

  localparam logic [OCC_W-1:0] CAP_V = OCC_W'(CAPACITY);

  state_t           state_q, state_d;
  op_t              op_q, op_d;
  logic             entry_q, exit_q;
  logic             pend_in, pend_out;
  logic             clr_in, clr_out;
  logic             rise_in, rise_out;
  logic [OCC_W-1:0] count_q, next_count_q;
  logic             ovf_q;
  logic             entry_grant_q, exit_grant_q, entry_reject_q, exit_reject_q;
  logic             entry_grant_d, exit_grant_d, entry_reject_d, exit_reject_d;
  logic             full, empty;
  logic [OCC_W-1:0] add_z;
  logic             add_cout;

  assign full     = (count_q == CAP_V);
  assign empty    = (count_q == '0);
  assign rise_in  = bus.entry_req & ~entry_q;
  assign rise_out = bus.exit_req  & ~exit_q;

  // Operands stay stable across CALC and COMMIT: count only moves on the COMMIT edge.
  adder_sub_8bit u_adder (
    .A    (count_q),
    .B    (8'd1),
    .sel  (op_q),
    .Z    (add_z),
    .Cout (add_cout)
  );

  // Edge detect and single-deep pending bits; a rise on the clearing edge still lands.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      entry_q  <= 1'b0;
      exit_q   <= 1'b0;
      pend_in  <= 1'b0;
      pend_out <= 1'b0;
    end else begin
      entry_q  <= bus.entry_req;
      exit_q   <= bus.exit_req;
      pend_in  <= (pend_in  & ~clr_in)  | rise_in;
      pend_out <= (pend_out & ~clr_out) | rise_out;
    end
  end

  // FSM state and latched operation.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      op_q    <= ADD;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
    end
  end

  // Next state and pulse decisions; a paired entry+exit nets to zero and skips the adder.
  always_comb begin
    state_d        = state_q;
    op_d           = op_q;
    clr_in         = 1'b0;
    clr_out        = 1'b0;
    entry_grant_d  = 1'b0;
    exit_grant_d   = 1'b0;
    entry_reject_d = 1'b0;
    exit_reject_d  = 1'b0;
    case (state_q)
      IDLE: begin
        if (pend_in && pend_out) begin
          entry_grant_d = 1'b1;
          exit_grant_d  = 1'b1;
          clr_in        = 1'b1;
          clr_out       = 1'b1;
        end else if (pend_out) begin
          clr_out = 1'b1;
          if (empty) begin
            exit_reject_d = 1'b1;
          end else begin
            op_d    = SUB;
            state_d = CALC;
          end
        end else if (pend_in) begin
          clr_in = 1'b1;
          if (full) begin
            entry_reject_d = 1'b1;
          end else begin
            op_d    = ADD;
            state_d = CALC;
          end
        end
      end
      CALC: begin
        state_d = COMMIT;
      end
      COMMIT: begin
        state_d       = IDLE;
        entry_grant_d = (op_q == ADD);
        exit_grant_d  = (op_q == SUB);
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Datapath: capture the adder result in CALC, publish it in COMMIT; carry on add is sticky.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q      <= '0;
      next_count_q <= '0;
      ovf_q        <= 1'b0;
    end else begin
      if (state_q == CALC) begin
        next_count_q <= add_z;
        if (op_q == ADD && add_cout) begin
          ovf_q <= 1'b1;
        end
      end
      if (state_q == COMMIT) begin
        count_q <= next_count_q;
      end
    end
  end

  // Registered one-cycle gate pulses.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      entry_grant_q  <= 1'b0;
      exit_grant_q   <= 1'b0;
      entry_reject_q <= 1'b0;
      exit_reject_q  <= 1'b0;
    end else begin
      entry_grant_q  <= entry_grant_d;
      exit_grant_q   <= exit_grant_d;
      entry_reject_q <= entry_reject_d;
      exit_reject_q  <= exit_reject_d;
    end
  end

  assign bus.entry_grant  = entry_grant_q;
  assign bus.exit_grant   = exit_grant_q;
  assign bus.entry_reject = entry_reject_q;
  assign bus.exit_reject  = exit_reject_q;
  assign bus.count        = count_q;
  assign bus.full         = full;
  assign bus.empty        = empty;
  assign bus.busy         = (state_q != IDLE);
  assign bus.ovf_err      = ovf_q;

endmodule
